// File: rtl/adc_config_sequencer_if.sv
// Host/stage-side signal bundle for adc_config_sequencer; the sequencer connects
// through the slave modport and the host side through the master modport.
interface adc_config_sequencer_if #(
  parameter int unsigned AW = 4
);
  logic          iStart;
  logic          iAbort;
  logic          iSkipHwReset;
  logic [AW:0]   iNumCmds;
  logic          iWrEn;
  logic [AW-1:0] iWrAddr;
  logic [23:0]   iWrData;
  logic          iAdcSdout;
  logic [7:0]    oAdcControlComm;
  logic [23:0]   oAdcSerialCmd;
  logic          oBusy;
  logic          oDone;
  logic [AW-1:0] oCmdIdx;
  logic          oWrReject;
  logic [15:0]   oReadback;

  modport master (
    output iStart, iAbort, iSkipHwReset, iNumCmds, iWrEn, iWrAddr, iWrData, iAdcSdout,
    input  oAdcControlComm, oAdcSerialCmd, oBusy, oDone, oCmdIdx, oWrReject, oReadback
  );

  modport slave (
    input  iStart, iAbort, iSkipHwReset, iNumCmds, iWrEn, iWrAddr, iWrData, iAdcSdout,
    output oAdcControlComm, oAdcSerialCmd, oBusy, oDone, oCmdIdx, oWrReject, oReadback
  );
endinterface

// File: rtl/adc_config_sequencer.sv
// Command-table sequencer driving the ADC control stage: HW reset, buffer/issue per entry, sync.
// Optional SDOUT readback capture is enabled by defining ADC_READBACK_EN.
module adc_config_sequencer #(
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned AW         = 4,
  parameter int unsigned RESET_HOLD = 8,
  parameter int unsigned BUF_HOLD   = 2,
  parameter int unsigned SHIFT_HOLD = 28,
  parameter int unsigned GAP_HOLD   = 4,
  parameter int unsigned SYNC_HOLD  = 4
) (
  input logic               adc_sclk,
  input logic               iReset_n,
  adc_config_sequencer_if.slave bus
);

  localparam int unsigned CW = 16;

  typedef enum logic [2:0] {
    S_IDLE, S_HWRST, S_POSTRST, S_BUF, S_ISSUE, S_GAP, S_SYNC, S_FIN
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [AW:0]   n_lat, n_nxt, n_start;
  logic [AW-1:0] idx, idx_nxt;
  logic [23:0]   tbl [DEPTH];
  logic [23:0]   cmd;
  logic [7:0]    comm;
  logic          done, wr_reject, busy, hold_end, last_entry, abort_now, start_now;
  logic [15:0]   readback;

  function automatic logic [CW-1:0] hold_of(input state_t s);
    case (s)
      S_HWRST:          hold_of = CW'(RESET_HOLD - 1);
      S_POSTRST, S_GAP: hold_of = CW'(GAP_HOLD - 1);
      S_BUF:            hold_of = CW'(BUF_HOLD - 1);
      S_ISSUE:          hold_of = CW'(SHIFT_HOLD - 1);
      S_SYNC:           hold_of = CW'(SYNC_HOLD - 1);
      default:          hold_of = '0;
    endcase
  endfunction

  function automatic logic [7:0] comm_of(input state_t s);
    case (s)
      S_HWRST: comm_of = 8'hFF;
      S_BUF:   comm_of = 8'h01;
      S_ISSUE: comm_of = 8'h02;
      S_SYNC:  comm_of = 8'h04;
      default: comm_of = 8'h00;
    endcase
  endfunction

  always_comb begin
    busy       = (state != S_IDLE);
    hold_end   = (cnt == '0);
    last_entry = ({1'b0, idx} == n_lat - 1'b1);
    abort_now  = busy && bus.iAbort;
    start_now  = !busy && bus.iStart && !bus.iAbort;
    n_start    = (bus.iNumCmds > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : bus.iNumCmds;
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    n_nxt     = n_lat;
    if (abort_now) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE: if (start_now) begin
          n_nxt     = n_start;
          idx_nxt   = '0;
          if (!bus.iSkipHwReset)  state_nxt = S_HWRST;
          else if (n_start == '0) state_nxt = S_SYNC;
          else                    state_nxt = S_BUF;
        end
        S_HWRST:   if (hold_end) state_nxt = S_POSTRST;
        S_POSTRST: if (hold_end) state_nxt = (n_lat == '0) ? S_SYNC : S_BUF;
        S_BUF:     if (hold_end) state_nxt = S_ISSUE;
        S_ISSUE:   if (hold_end) state_nxt = S_GAP;
        S_GAP: if (hold_end) begin
          if (last_entry) begin
            state_nxt = S_SYNC;
          end else begin
            idx_nxt   = idx + 1'b1;
            state_nxt = S_BUF;
          end
        end
        S_SYNC:    if (hold_end) state_nxt = S_FIN;
        S_FIN:     state_nxt = S_IDLE;
        default:   state_nxt = S_IDLE;
      endcase
    end
    // Reload on every entry; otherwise count down and park at zero (IDLE never leaves via count).
    if (state_nxt != state) cnt_nxt = hold_of(state_nxt);
    else if (hold_end)      cnt_nxt = cnt;
    else                    cnt_nxt = cnt - 1'b1;
  end

  always_ff @(posedge adc_sclk) begin
    if (!iReset_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      n_lat     <= '0;
      idx       <= '0;
      cmd       <= '0;
      comm      <= '0;
      done      <= 1'b0;
      wr_reject <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      n_lat     <= n_nxt;
      idx       <= idx_nxt;
      comm      <= comm_of(state_nxt);
      wr_reject <= bus.iWrEn && busy;
      if (abort_now)
        cmd <= '0;
      else if (state_nxt == S_BUF && state != S_BUF)
        cmd <= tbl[idx_nxt];
      if (start_now)
        done <= 1'b0;
      else if (state == S_FIN && !bus.iAbort)
        done <= 1'b1;
    end
  end

  // Table is intentionally not cleared by reset.
  always_ff @(posedge adc_sclk) begin
    if (bus.iWrEn && !busy)
      tbl[bus.iWrAddr] <= bus.iWrData;
  end

`ifdef ADC_READBACK_EN
  logic [15:0] rb_shift;

  // Only the low 16 of the 24 shifted bits are ever published, so a 16-bit shifter suffices.
  always_ff @(posedge adc_sclk) begin
    if (!iReset_n) begin
      rb_shift <= '0;
      readback <= '0;
    end else begin
      if (state == S_ISSUE && cnt >= CW'(SHIFT_HOLD - 24))
        rb_shift <= {rb_shift[14:0], bus.iAdcSdout};
      if (state == S_ISSUE && state_nxt == S_GAP)
        readback <= rb_shift;
    end
  end
`else
  logic unused_sdout;
  always_comb begin
    unused_sdout = bus.iAdcSdout;
    readback     = '0;
  end
`endif

  assign bus.oAdcControlComm = comm;
  assign bus.oAdcSerialCmd   = cmd;
  assign bus.oBusy           = busy;
  assign bus.oDone           = done;
  assign bus.oCmdIdx         = idx;
  assign bus.oWrReject       = wr_reject;
  assign bus.oReadback       = readback;

endmodule
